sum_accumulator: RTL

Downstream consumer of the 6-bit ripple-carry adder stage. It accepts a batch of 1 to 8 of the adder's 7-bit sums over a valid/ready handshake and accumulates them into a 10-bit total. It then holds the total on a registered valid/ready output until the sink takes it. This gives the adder lab chain its first sequential stage: batching, flow control and a small FSM.

---
 rtl/sum_accumulator_pkg.sv | 23 ++
 rtl/sum_acc_ctrl.sv | 77 +++++++
 rtl/sum_accumulator.sv | 93 +++++++++
 3 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum_accumulator block: state encoding, default widths
// and the state decode that folds the unused code back onto IDLE.
package sum_accumulator_pkg;

  localparam int unsigned SUM_WIDTH_DEF = 7;
  localparam int unsigned LEN_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Code 2'd3 is unreachable; treating it as IDLE makes a corrupted state self-recover.
  function automatic state_e decode_state(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_state = ST_ACC;
      2'd2:    decode_state = ST_DONE;
      default: decode_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sum_acc_ctrl.sv
// Batch controller: IDLE/ACC/DONE FSM, latched batch length and sample index.
// Emits the handshake flags plus clear/accumulate strobes for the datapath.
module sum_acc_ctrl
  import sum_accumulator_pkg::*;
#(
  parameter int P_LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [P_LEN_WIDTH-1:0] len_i,
  input  logic                   valid_i,
  input  logic                   sink_ready_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   clear_o,
  output logic                   accum_o,
  output logic [1:0]             state_o
);

  // Handshake: a sum moves when valid_i & ready_o at a rising edge; the total moves when
  // valid_o & sink_ready_i. Neither flag depends combinationally on its partner signal.
  logic [1:0]             state_q, state_d;
  logic [P_LEN_WIDTH-1:0] len_q, len_d;
  logic [P_LEN_WIDTH-1:0] idx_q, idx_d;
  state_e                 state_cur;

  assign state_cur = decode_state(state_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_cur)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACC;
          len_d   = len_i;
          idx_d   = '0;
        end
      end
      ST_ACC: begin
        if (valid_i) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (sink_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_cur == ST_ACC);
    valid_o = (state_cur == ST_DONE);
    busy_o  = (state_cur != ST_IDLE);
    clear_o = (state_cur == ST_IDLE) && start_i;
    accum_o = (state_cur == ST_ACC) && valid_i;
    state_o = state_cur;
  end

endmodule

// File: rtl/sum_accumulator.sv
// Batching accumulator for adder sums with registered valid/ready result.
// Optional running-maximum output enabled by defining SUM_ACC_MAX_EN.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int P_SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int P_LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                           i_w_clk,
  input  logic                           i_w_rst_n,
  input  logic                           i_w_start,
  input  logic [P_LEN_WIDTH-1:0]         i_w_len,
  input  logic                           i_w_valid,
  input  logic [P_SUM_WIDTH-1:0]         i_w_sum,
  output logic                           o_w_ready,
  output logic                           o_w_valid,
  input  logic                           i_w_ready,
  output logic [P_SUM_WIDTH+P_LEN_WIDTH-1:0] o_w_total,
  output logic [P_LEN_WIDTH:0]           o_w_count,
  output logic                           o_w_busy,
`ifdef SUM_ACC_MAX_EN
  output logic [P_SUM_WIDTH-1:0]         o_w_max,
`endif
  output logic [1:0]                     o_w_state
);

  localparam int TW = P_SUM_WIDTH + P_LEN_WIDTH;

  logic                  clear_s, accum_s;
  logic [TW-1:0]         acc_q, acc_d;
  logic [P_LEN_WIDTH:0]  cnt_q, cnt_d;

  sum_acc_ctrl #(
    .P_LEN_WIDTH(P_LEN_WIDTH)
  ) u_ctrl (
    .clk_i       (i_w_clk),
    .rst_ni      (i_w_rst_n),
    .start_i     (i_w_start),
    .len_i       (i_w_len),
    .valid_i     (i_w_valid),
    .sink_ready_i(i_w_ready),
    .ready_o     (o_w_ready),
    .valid_o     (o_w_valid),
    .busy_o      (o_w_busy),
    .clear_o     (clear_s),
    .accum_o     (accum_s),
    .state_o     (o_w_state)
  );

  // 8 x 126 fits in 10 bits, so the sum never needs saturation.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_s) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accum_s) begin
      acc_d = acc_q + {{P_LEN_WIDTH{1'b0}}, i_w_sum};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_w_total = acc_q;
  assign o_w_count = cnt_q;

`ifdef SUM_ACC_MAX_EN
  logic [P_SUM_WIDTH-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (clear_s) max_d = '0;
    else if (accum_s && (i_w_sum > max_q)) max_d = i_w_sum;
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) max_q <= '0;
    else            max_q <= max_d;
  end

  assign o_w_max = max_q;
`endif

endmodule
